// File: rtl/sc_speedcompare.sv
// sc_speedcompare: periodic tick generator sitting behind the speed counter.
// Compares the count against a level-selected threshold, emits a one-cycle
// tick and drives the counter's clear/enable. Also holds the user speed
// level (faster/slower buttons) and the run/pause toggle.
module sc_speedcompare #(
   parameter int SPEEDCOMPARE_DATAWIDTH = 28,
   parameter int SPEEDCOMPARE_LEVEL0    = 50_000_000,
   parameter int SPEEDCOMPARE_LEVEL1    = 25_000_000,
   parameter int SPEEDCOMPARE_LEVEL2    = 12_500_000,
   parameter int SPEEDCOMPARE_LEVEL3    = 6_250_000
) (
   input  logic                              SC_SPEEDCOMPARE_CLOCK_50,
   input  logic                              SC_SPEEDCOMPARE_RESET_InHigh,
   input  logic [SPEEDCOMPARE_DATAWIDTH-1:0] SC_SPEEDCOMPARE_data_InBUS,
   input  logic                              SC_SPEEDCOMPARE_faster_InLow,
   input  logic                              SC_SPEEDCOMPARE_slower_InLow,
   input  logic                              SC_SPEEDCOMPARE_pause_InLow,
   output logic                              SC_SPEEDCOMPARE_tick_OutHigh,
   output logic                              SC_SPEEDCOMPARE_counterClear_OutHigh,
   output logic                              SC_SPEEDCOMPARE_counterUp_OutLow,
   output logic [1:0]                        SC_SPEEDCOMPARE_level_OutBUS
);

   // Threshold is period minus 2: one cycle for the TICK state and one
   // because the counter reads 0 in the first RUN cycle after a clear.
   localparam logic [SPEEDCOMPARE_DATAWIDTH-1:0] THR0 = SPEEDCOMPARE_DATAWIDTH'(SPEEDCOMPARE_LEVEL0 - 2);
   localparam logic [SPEEDCOMPARE_DATAWIDTH-1:0] THR1 = SPEEDCOMPARE_DATAWIDTH'(SPEEDCOMPARE_LEVEL1 - 2);
   localparam logic [SPEEDCOMPARE_DATAWIDTH-1:0] THR2 = SPEEDCOMPARE_DATAWIDTH'(SPEEDCOMPARE_LEVEL2 - 2);
   localparam logic [SPEEDCOMPARE_DATAWIDTH-1:0] THR3 = SPEEDCOMPARE_DATAWIDTH'(SPEEDCOMPARE_LEVEL3 - 2);

   // Encoding chosen so every output is a bare state flop: bit1 = counterUp,
   // bit0 = tick/clear. Clear feeds an async reset, so it must not glitch.
   typedef enum logic [1:0] {
      RUN   = 2'b00,
      PAUSE = 2'b10,
      TICK  = 2'b11
   } state_t;

   state_t                              state;
   state_t                              state_next;
   logic [1:0]                          faster_sync;
   logic [1:0]                          slower_sync;
   logic [1:0]                          pause_sync;
   logic                                faster_prev;
   logic                                slower_prev;
   logic                                pause_prev;
   logic                                faster_edge;
   logic                                slower_edge;
   logic                                pause_edge;
   logic [1:0]                          level;
   logic [SPEEDCOMPARE_DATAWIDTH-1:0]   threshold;
   logic                                reached;

   // Button synchronizers and edge-history flops; idle-high so reset never fakes an edge.
   always_ff @(posedge SC_SPEEDCOMPARE_CLOCK_50 or posedge SC_SPEEDCOMPARE_RESET_InHigh) begin
      if (SC_SPEEDCOMPARE_RESET_InHigh) begin
         faster_sync <= '1;
         slower_sync <= '1;
         pause_sync  <= '1;
         faster_prev <= 1'b1;
         slower_prev <= 1'b1;
         pause_prev  <= 1'b1;
      end else begin
         faster_sync <= {faster_sync[0], SC_SPEEDCOMPARE_faster_InLow};
         slower_sync <= {slower_sync[0], SC_SPEEDCOMPARE_slower_InLow};
         pause_sync  <= {pause_sync[0], SC_SPEEDCOMPARE_pause_InLow};
         faster_prev <= faster_sync[1];
         slower_prev <= slower_sync[1];
         pause_prev  <= pause_sync[1];
      end
   end

   // Falling-edge detection on the synchronized buttons.
   always_comb begin
      faster_edge = faster_prev & ~faster_sync[1];
      slower_edge = slower_prev & ~slower_sync[1];
      pause_edge  = pause_prev & ~pause_sync[1];
   end

   // Speed level: saturating up/down, simultaneous presses cancel.
   always_ff @(posedge SC_SPEEDCOMPARE_CLOCK_50 or posedge SC_SPEEDCOMPARE_RESET_InHigh) begin
      if (SC_SPEEDCOMPARE_RESET_InHigh) begin
         level <= '0;
      end else if (faster_edge && !slower_edge && level != 2'd3) begin
         level <= level + 2'd1;
      end else if (slower_edge && !faster_edge && level != 2'd0) begin
         level <= level - 2'd1;
      end
   end

   // Threshold select and unsigned compare against the live count.
   always_comb begin
      unique case (level)
         2'd0:    threshold = THR0;
         2'd1:    threshold = THR1;
         2'd2:    threshold = THR2;
         default: threshold = THR3;
      endcase
      reached = (SC_SPEEDCOMPARE_data_InBUS >= threshold);
   end

   // State register.
   always_ff @(posedge SC_SPEEDCOMPARE_CLOCK_50 or posedge SC_SPEEDCOMPARE_RESET_InHigh) begin
      if (SC_SPEEDCOMPARE_RESET_InHigh) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: pause wins over the compare; pause edges in TICK are dropped.
   always_comb begin
      state_next = RUN;
      unique case (state)
         RUN: begin
            if (pause_edge) begin
               state_next = PAUSE;
            end else if (reached) begin
               state_next = TICK;
            end else begin
               state_next = RUN;
            end
         end
         TICK:  state_next = RUN;
         PAUSE: state_next = pause_edge ? RUN : PAUSE;
         default: state_next = RUN;
      endcase
   end

   // Outputs taken straight from the state flops and level register.
   always_comb begin
      SC_SPEEDCOMPARE_tick_OutHigh         = state[0];
      SC_SPEEDCOMPARE_counterClear_OutHigh = state[0];
      SC_SPEEDCOMPARE_counterUp_OutLow     = state[1];
      SC_SPEEDCOMPARE_level_OutBUS         = level;
   end

endmodule
